// File: rtl/tt_um_marno_compose_if.sv
`default_nettype none
// ============================================================================
// Module      : tt_um_marno_compose_if
// Description : Tiny Tapeout pin bundle for the compose tile.
//               master  : drives the dedicated/bidir inputs (harness side)
//               slave   : the tile itself
//               ui_in   [7:0] dedicated inputs
//               uo_out  [7:0] dedicated outputs
//               uio_in  [7:0] bidir inputs (unused by the tile)
//               uio_out [7:0] bidir outputs
//               uio_oe  [7:0] bidir output enables
//               ena           tile enable (unused by the tile)
// Revision    : 1.0 - initial release
// ============================================================================
interface tt_um_marno_compose_if;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       ena;

    modport master (
        output ui_in,
        output uio_in,
        output ena,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ui_in,
        input  uio_in,
        input  ena,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface
`default_nettype wire

// File: rtl/tt_um_marno_compose.sv
`default_nettype none
// ============================================================================
// Module      : seg7decoder
// Description : Hex nibble to 7-segment pattern, bit order {g,f,e,d,c,b,a},
//               active-high segments.
//               value    [3:0] nibble in
//               segments [6:0] segment pattern out
// Revision    : 1.0 - initial release
// ============================================================================
module seg7decoder (
    input  wire logic [3:0] value,
    output logic      [6:0] segments
);
    always_comb begin
        segments = 7'b0000000;
        case (value)
            4'h0: segments = 7'b0111111;
            4'h1: segments = 7'b0000110;
            4'h2: segments = 7'b1011011;
            4'h3: segments = 7'b1001111;
            4'h4: segments = 7'b1100110;
            4'h5: segments = 7'b1101101;
            4'h6: segments = 7'b1111101;
            4'h7: segments = 7'b0000111;
            4'h8: segments = 7'b1111111;
            4'h9: segments = 7'b1101111;
            4'hA: segments = 7'b1110111;
            4'hB: segments = 7'b1111100;
            4'hC: segments = 7'b0111001;
            4'hD: segments = 7'b1011110;
            4'hE: segments = 7'b1111001;
            4'hF: segments = 7'b1110001;
            default: segments = 7'b0000000;
        endcase
    end
endmodule

// ============================================================================
// Module      : tt_um_marno_compose
// Description : Running-product calculator. Factor digits entered on the
//               switches are multiplied into a 16-bit product with a
//               shift-and-add multiplier (one factor bit per clock). The
//               product is shown MSB nibble first on the 7-segment display,
//               one nibble per display slot, followed by a blank slot.
//               clk           clock
//               rst_n         asynchronous active-low reset
//               bus.ui_in     [3:0] factor digit, [5] uio byte select,
//                             [6] clear (level), [7] enter (rising edge)
//               bus.uo_out    [6:0] segments, [7] status flag
//               bus.uio_out   product low/high byte, chosen by ui_in[5]
//               bus.uio_oe    all outputs enabled
//               Optional: define COMPOSE_PRIME_ONLY_EN to accept only prime
//               digits (2,3,5,7,B,D); rejected digits raise a sticky flag
//               that is ORed into uo_out[7].
// Revision    : 1.0 - initial release
// ============================================================================
module tt_um_marno_compose #(
    parameter logic [23:0] MAX_COUNT = 24'd10_000_000
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    tt_um_marno_compose_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    localparam logic [2:0] C_SLOT_BLANK = 3'd4;

    state_t      r_state;
    logic [15:0] r_product;
    logic        r_ovf;
    logic [3:0]  r_factor;
    logic [19:0] r_acc;
    logic [1:0]  r_idx;

    logic        r_clr_s1;
    logic        r_clr_s2;
    logic        r_ent_s1;
    logic        r_ent_s2;
    logic        r_ent_prev;

    logic [23:0] r_cnt;
    logic [2:0]  r_slot;

    logic        w_clr;
    logic        w_enter_rise;
    logic [3:0]  w_digit;
    logic        w_accept;
    logic [19:0] w_partial;
    logic [19:0] w_acc_next;
    logic        w_restart;
    logic        w_flag;
    logic [3:0]  w_nibble;
    logic [6:0]  w_seg;
    logic        w_unused;

    assign w_unused     = &{1'b0, bus.uio_in, bus.ena, bus.ui_in[4]};

    assign w_clr        = r_clr_s2;
    assign w_enter_rise = r_ent_s2 & ~r_ent_prev;
    // The digit is sampled unsynchronized; the user holds the switches
    // steady well before pressing enter, so only enter/clear need syncing.
    assign w_digit      = bus.ui_in[3:0];

`ifdef COMPOSE_PRIME_ONLY_EN
    always_comb begin
        w_accept = 1'b0;
        case (w_digit)
            4'h2, 4'h3, 4'h5, 4'h7, 4'hB, 4'hD: w_accept = 1'b1;
            default:                            w_accept = 1'b0;
        endcase
    end
`else
    assign w_accept = (w_digit != 4'h0);
`endif

    // Shift-and-add step: bit r_idx of the factor selects product << r_idx.
    // A 4-bit factor times a 16-bit product always fits in 20 bits.
    assign w_partial  = r_factor[r_idx] ? ({4'b0000, r_product} << r_idx) : 20'd0;
    assign w_acc_next = r_acc + w_partial;

    // Display restarts whenever the shown value changes: on clear, or on the
    // final multiply step that writes the product (clear wins if both).
    assign w_restart  = w_clr || ((r_state == ST_MUL) && (r_idx == 2'd3));

    // ------------------------------------------------------------------
    // Input synchronizers and multiply state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_s1   <= 1'b0;
            r_clr_s2   <= 1'b0;
            r_ent_s1   <= 1'b0;
            r_ent_s2   <= 1'b0;
            r_ent_prev <= 1'b0;
            r_state    <= ST_IDLE;
            r_product  <= 16'h0001;
            r_ovf      <= 1'b0;
            r_factor   <= 4'h0;
            r_acc      <= 20'd0;
            r_idx      <= 2'd0;
        end else begin
            r_clr_s1   <= bus.ui_in[6];
            r_clr_s2   <= r_clr_s1;
            r_ent_s1   <= bus.ui_in[7];
            r_ent_s2   <= r_ent_s1;
            r_ent_prev <= r_ent_s2;

            case (r_state)
                ST_IDLE: begin
                    if (w_clr) begin
                        r_product <= 16'h0001;
                        r_ovf     <= 1'b0;
                    end else if (w_enter_rise && w_accept) begin
                        r_factor <= w_digit;
                        r_acc    <= 20'd0;
                        r_idx    <= 2'd0;
                        r_state  <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (w_clr) begin
                        r_product <= 16'h0001;
                        r_ovf     <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_acc <= w_acc_next;
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_product <= w_acc_next[15:0];
                            r_ovf     <= r_ovf | (w_acc_next[19:16] != 4'h0);
                            r_state   <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef COMPOSE_PRIME_ONLY_EN
    // Sticky reject: set by a refused nonzero digit taken in IDLE, cleared
    // by the next accepted digit or by clear.
    logic r_reject;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reject <= 1'b0;
        end else if (w_clr) begin
            r_reject <= 1'b0;
        end else if ((r_state == ST_IDLE) && w_enter_rise && (w_digit != 4'h0)) begin
            r_reject <= ~w_accept;
        end
    end

    assign w_flag = r_ovf | r_reject;
`else
    assign w_flag = r_ovf;
`endif

    // ------------------------------------------------------------------
    // Display slot rotation
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= 24'd0;
            r_slot <= 3'd0;
        end else if (w_restart) begin
            r_cnt  <= 24'd0;
            r_slot <= 3'd0;
        end else if (r_cnt == MAX_COUNT - 24'd1) begin
            r_cnt  <= 24'd0;
            r_slot <= (r_slot == C_SLOT_BLANK) ? 3'd0 : r_slot + 3'd1;
        end else begin
            r_cnt  <= r_cnt + 24'd1;
        end
    end

    always_comb begin
        w_nibble = 4'h0;
        case (r_slot)
            3'd0:    w_nibble = r_product[15:12];
            3'd1:    w_nibble = r_product[11:8];
            3'd2:    w_nibble = r_product[7:4];
            3'd3:    w_nibble = r_product[3:0];
            default: w_nibble = 4'h0;
        endcase
    end

    seg7decoder u_seg7decoder (
        .value    (w_nibble),
        .segments (w_seg)
    );

    assign bus.uo_out  = {w_flag, (r_slot == C_SLOT_BLANK) ? 7'b0000000 : w_seg};
    assign bus.uio_out = bus.ui_in[5] ? r_product[15:8] : r_product[7:0];
    assign bus.uio_oe  = 8'hFF;

endmodule
`default_nettype wire

// File: tb/tb_tt_um_marno_compose.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_um_marno_compose
// Description : Self-checking bench for tt_um_marno_compose with a fast
//               display (MAX_COUNT=4) and an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_um_marno_compose;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    // Reference model state
    int   m_product;
    bit   m_ovf;
    bit   m_reject;

    tt_um_marno_compose_if bus ();

    tt_um_marno_compose #(
        .MAX_COUNT (24'd4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Glyphs for hex digits, {g,f,e,d,c,b,a}
    function automatic logic [6:0] glyph(input int v);
        case (v)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F; 10: return 7'h77; 11: return 7'h7C;
           12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++)
            if (n % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit digit_accepted(input int d);
`ifdef COMPOSE_PRIME_ONLY_EN
        return is_prime(d);
`else
        return d != 0;
`endif
    endfunction

    function automatic bit model_flag();
`ifdef COMPOSE_PRIME_ONLY_EN
        return m_ovf | m_reject;
`else
        return m_ovf;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_product(output logic [15:0] p);
        bus.ui_in[5] = 1'b0;
        #1 p[7:0] = bus.uio_out;
        bus.ui_in[5] = 1'b1;
        #1 p[15:8] = bus.uio_out;
        bus.ui_in[5] = 1'b0;
        #1;
    endtask

    task automatic check_state(input string tag);
        logic [15:0] p;
        read_product(p);
        check({tag, "_product"}, p, m_product[15:0]);
        check({tag, "_flag"}, bus.uo_out[7], model_flag());
    endtask

    // Enter one digit with a one-cycle pulse. inject adds a second enter
    // pulse that lands while the multiply runs; abort raises clear mid-multiply.
    task automatic enter(input int d, input bit inject, input bit abort);
        logic [15:0] p;
        int          full;
        bit          acc;
        acc = digit_accepted(d);
        bus.ui_in[3:0] = d[3:0];
        bus.ui_in[7]   = 1'b1;
        tick();                      // edge 1
        bus.ui_in[7]   = 1'b0;
        tick();                      // edge 2
        tick();                      // edge 3
        if (inject) bus.ui_in[7] = 1'b1;
        if (abort)  bus.ui_in[6] = 1'b1;
        tick();                      // edge 4
        bus.ui_in[7]   = 1'b0;
        tick();                      // edge 5
        tick();                      // edge 6
        if (!abort)
            check("pre_write_low", bus.uio_out, m_product[7:0]);
        tick();                      // edge 7
        if (abort) begin
            m_product = 1;
            m_ovf     = 1'b0;
            m_reject  = 1'b0;
        end else if (d != 0) begin
            if (acc) begin
                full      = m_product * d;
                m_ovf     = m_ovf | (full > 65535);
                m_product = full & 16'hFFFF;
                m_reject  = 1'b0;
            end else begin
                m_reject  = 1'b1;
            end
        end
        if (acc || abort)
            check("restart_slot0", bus.uo_out[6:0], glyph((m_product >> 12) & 15));
        check_state("enter");
        if (abort) begin
            bus.ui_in[6] = 1'b0;
            repeat (3) tick();
            read_product(p);
            check("abort_hold", p, 16'h0001);
        end
        tick();
    endtask

    task automatic do_clear();
        bus.ui_in[6] = 1'b1;
        repeat (3) tick();
        bus.ui_in[6] = 1'b0;
        tick();
        tick();                      // last edge at which clear is seen
        m_product = 1;
        m_ovf     = 1'b0;
        m_reject  = 1'b0;
        check("clear_slot0", bus.uo_out[6:0], glyph(0));
        check_state("clear");
        tick();
    endtask

    initial begin
        logic [15:0] p;
        int          slot;
        logic [6:0]  exp_seg;
        int          r;
        total = 0;
        bad   = 0;
        m_product = 1;
        m_ovf     = 1'b0;
        m_reject  = 1'b0;

        rst_n      = 1'b0;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;
        bus.ena    = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state and display rotation: 0,0,0,1,blank, 4 clocks each
        check("reset_oe", bus.uio_oe, 8'hFF);
        check("reset_flag", bus.uo_out[7], 1'b0);
        for (int k = 0; k <= 22; k++) begin
            slot    = (k / 4) % 5;
            exp_seg = (slot == 4) ? 7'h00 : glyph((m_product >> (4 * (3 - slot))) & 15);
            check("reset_disp", bus.uo_out[6:0], exp_seg);
            if (k < 22) tick();
        end
        read_product(p);
        check("reset_product", p, 16'h0001);
        check("reset_low_byte", p[7:0], 8'h01);
        tick();

        // 3 * 5 * 7
        enter(3, 0, 0);
        enter(5, 0, 0);
        enter(7, 0, 0);
        read_product(p);
        check("prod_105", p, 16'h0069);

        // 15^4 then * 2 overflows
        do_clear();
`ifndef COMPOSE_PRIME_ONLY_EN
        for (int k = 0; k < 4; k++) enter(15, 0, 0);
        read_product(p);
        check("prod_50625", p, 16'hC5C1);
        check("no_ovf_yet", bus.uo_out[7], 1'b0);
        enter(2, 0, 0);
        read_product(p);
        check("prod_wrap", p, 16'h8B82);
        check("ovf_flag", bus.uo_out[7], 1'b1);
`endif

        // Clear two cycles into the multiply aborts it
        enter(5, 0, 0);
        enter(3, 0, 1);

        // Enter during multiply ignored; digit 0 ignored
        enter(3, 1, 0);
        read_product(p);
        check("inject_ignored", p, 16'h0003);
        enter(0, 0, 0);
        read_product(p);
        check("zero_ignored", p, 16'h0003);
`ifndef COMPOSE_PRIME_ONLY_EN
        enter(1, 0, 0);
        read_product(p);
        check("factor_one", p, 16'h0003);
`endif

`ifdef COMPOSE_PRIME_ONLY_EN
        do_clear();
        enter(4, 0, 0);
        read_product(p);
        check("prime_reject_prod", p, 16'h0001);
        check("prime_reject_flag", bus.uo_out[7], 1'b1);
        enter(2, 0, 0);
        read_product(p);
        check("prime_accept_prod", p, 16'h0002);
        check("prime_accept_flag", bus.uo_out[7], 1'b0);
`endif

        // Randomized digits with occasional clears
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) do_clear();
            else        enter($urandom_range(0, 15), 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tt_um_marno_compose.md
Name: tt_um_marno_compose

Overview:
- Inverse of the factorizer tile: the user enters factors one at a time on the switches, and the block multiplies them into a running 16-bit product.
- The product is shown on the 7-segment display as four hex nibbles in rotation, MSB first, one per display period.
- Product and overflow are also exposed on the bidirectional pins.
- Tiny Tapeout top-level tile. Uses the existing seg7decoder (4-bit value in, 7-bit segments out).

Parameters:
- MAX_COUNT, 24'd10_000_000: clocks per display slot (1 s at 10 MHz).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-low
- ui_in  input  8  [3:0] factor digit; [5] uio byte select; [6] clear (level); [7] enter (rising edge)
- uo_out  output  8  [6:0] segments from seg7decoder; [7] status flag
- uio_in  input  8  unused
- uio_out  output  8  ui_in[5]=0: product[7:0]; ui_in[5]=1: product[15:8]
- uio_oe  output  8  constant 8'hFF
- ena  input  1  unused

Behaviour:
- Reset (rst_n low, async):
  - product=16'h0001, ovf=0, state=IDLE.
  - Slot counter=0, slot=0, synchronizers=0.
  - uo_out shows digit 0; uo_out[7]=0; uio_out reflects product=1.
- ui_in[7:6]: each passes through a 2-flop synchronizer. enter_rise = synced enter high and previous synced value low.
- State machine has two states, IDLE and MUL.
- IDLE:
  - If clear (synced) is high: product<=1, ovf<=0, display restarts. Clear has priority over enter.
  - Else if enter_rise and ui_in[3:0] != 0: latch factor=ui_in[3:0], acc<=0, bit index i<=0, go to MUL.
  - Factor 0 is ignored and does not change state.
- MUL: four cycles, i=0..3.
  - Each cycle: if factor[i], acc(20-bit) <= acc + (product << i).
  - On i=3, the final acc is computed, then product<=acc[15:0], ovf<=ovf | (acc[19:16]!=0), return to IDLE, display restarts.
- Latency: ui_in[7] first sampled high at edge 1 → rise detected after edge 2 → MUL entered at edge 3 → product written at edge 7.
- Enter edges during MUL are ignored; they are not queued.
- Clear during MUL aborts the multiply, sets product<=1 and ovf<=0, and returns to IDLE the next edge.
- Factor 1: runs all 4 cycles; product is unchanged.
- ovf is sticky until clear or reset. The product wraps modulo 2^16.
- Display slots:
  - Slot 0: product[15:12]. Slot 1: [11:8]. Slot 2: [7:4]. Slot 3: [3:0]. Slot 4: blank (segments 7'b0).
  - Leading zeros are shown.
  - Slot advances when the slot counter == MAX_COUNT-1; the counter then resets to 0. Slot 4 wraps to 0.
- Display restart: slot<=0 and slot counter<=0, on product write or clear.
- uo_out[7] = ovf (plus reject, see optional feature). uo_out[7] is held combinationally from registers.

Optional Feature:
- Macro: COMPOSE_PRIME_ONLY_EN.
- Defined:
  - Only factor digits 2, 3, 5, 7, B and D are accepted.
  - Any other nonzero digit on enter_rise is ignored and sets a sticky reject flag.
  - reject clears on the next accepted entry, on clear, or on reset.
  - uo_out[7] = ovf | reject.
- Undefined: digits 1..F are accepted, there is no reject logic, and uo_out[7] = ovf.

Test Plan:
- Reset, MAX_COUNT=4 → uio_out=8'h01; display slots show 0,0,0,1,blank, changing every 4 clocks, then wrap.
- Enter 3, then 5, then 7 → product=16'h0069 (105); uio_out=8'h69 written exactly 7 edges after each enter is first sampled; ovf=0.
- Enter F four times → 16'hC5C1 (50625); ovf=0. Enter 2 → product=16'h8B82, ovf=1, uo_out[7]=1.
- Clear, asserted 2 cycles into MUL → multiply aborted; product=1, ovf=0, display restarted at slot 0.
- Enter rising during MUL → ignored; product reflects only the first factor. Enter digit 0 → no change.
- With COMPOSE_PRIME_ONLY_EN: enter 4 → product unchanged, uo_out[7]=1. Then enter 2 → product=2, uo_out[7]=0.
